// File: rtl/sand_grid_if.sv
`default_nettype none
// ============================================================================
// Module : sand_grid_if
// Brief  : Step/seed/accel inputs and occupancy outputs of the sand engine.
// Rev    : 1.0  initial release
// ============================================================================
interface sand_grid_if;
    logic                step;
    logic signed [15:0]  accel_x;
    logic signed [15:0]  accel_y;
    logic                wr_en;
    logic [3:0]          wr_row;
    logic [3:0]          wr_col;
    logic                wr_val;
    logic [15:0][15:0]   matrix;
    logic [8:0]          grains;
    logic                busy;
    logic                pass_done;

    modport master (
        output step, accel_x, accel_y, wr_en, wr_row, wr_col, wr_val,
        input  matrix, grains, busy, pass_done
    );

    modport slave (
        input  step, accel_x, accel_y, wr_en, wr_row, wr_col, wr_val,
        output matrix, grains, busy, pass_done
    );
endinterface
`default_nettype wire

// File: rtl/sand_grid.sv
`default_nettype none
// ============================================================================
// Module : sand_grid
// Brief  : 16x16 falling-sand engine, one gravity pass per step, double-buffered
//          display. Optional diagonal slides enabled by macro SAND_DIAGONAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
module sand_grid #(
    parameter logic signed [15:0] THRESH = 16'sd2000
) (
    input  logic        clock,
    input  logic        reset,
    sand_grid_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SCAN   = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;

    localparam logic [2:0] c_DIR_NONE  = 3'd0;
    localparam logic [2:0] c_DIR_DOWN  = 3'd1;
    localparam logic [2:0] c_DIR_UP    = 3'd2;
    localparam logic [2:0] c_DIR_RIGHT = 3'd3;
    localparam logic [2:0] c_DIR_LEFT  = 3'd4;

    localparam logic [15:0]        c_THRESH_U   = THRESH;
    localparam logic [15:0][15:0]  c_RESET_GRID = {{12{16'h0000}}, {4{16'hFFFF}}};

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [2:0]          r_dir;
    logic [3:0]          r_line;
    logic [3:0]          r_idx;
    logic                r_commit;
    logic                r_pass_done;
    logic [15:0][15:0]   r_work;
    logic [15:0][15:0]   r_matrix;

    logic [15:0]         w_abs_x;
    logic [15:0]         w_abs_y;
    logic [2:0]          w_dir;
    logic                w_busy;
    logic                w_accept;
    logic                w_seed;
    logic                w_scan_last;
    logic [3:0]          w_src_r;
    logic [3:0]          w_src_c;
    logic [3:0]          w_dst_r;
    logic [3:0]          w_dst_c;
    logic                w_vert;
    logic                w_src_occ;
    logic                w_dst_occ;
    logic                w_move;
    logic [3:0]          w_mv_r;
    logic [3:0]          w_mv_c;
    logic [255:0]        w_flat;
    logic [8:0]          w_grains;

    function automatic logic [15:0] sat_abs(input logic signed [15:0] a);
        if (a == 16'sh8000) return 16'h7FFF;
        return a[15] ? 16'(-a) : 16'(a);
    endfunction

    // Direction decode; ties between axes resolve to x.
    always_comb begin
        w_abs_x = sat_abs(bus.accel_x);
        w_abs_y = sat_abs(bus.accel_y);
        w_dir   = c_DIR_NONE;
        if ((w_abs_x >= w_abs_y) && (w_abs_x > c_THRESH_U))
            w_dir = bus.accel_x[15] ? c_DIR_LEFT : c_DIR_RIGHT;
        else if (w_abs_y > c_THRESH_U)
            w_dir = bus.accel_y[15] ? c_DIR_UP : c_DIR_DOWN;
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    assign w_scan_last = (r_line == 4'd14) && (r_idx == 4'd15);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (bus.step)
                          w_state_next = (w_dir == c_DIR_NONE) ? c_COMMIT : c_SCAN;
            c_SCAN:   if (w_scan_last) w_state_next = c_COMMIT;
            c_COMMIT: w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state == c_SCAN) || (r_state == c_COMMIT);
        w_accept = (r_state == c_IDLE) && bus.step;
        w_seed   = (r_state == c_IDLE) && bus.wr_en && !bus.step;
    end

    // Scan order starts at the line adjacent to the leading edge and walks backwards,
    // so a moved grain always lands in a line that has already been visited.
    always_comb begin
        w_src_r = '0;
        w_src_c = '0;
        w_dst_r = '0;
        w_dst_c = '0;
        w_vert  = 1'b1;
        case (r_dir)
            c_DIR_DOWN: begin
                w_src_r = 4'd14 - r_line;
                w_src_c = r_idx;
                w_dst_r = w_src_r + 4'd1;
                w_dst_c = r_idx;
            end
            c_DIR_UP: begin
                w_src_r = r_line + 4'd1;
                w_src_c = r_idx;
                w_dst_r = r_line;
                w_dst_c = r_idx;
            end
            c_DIR_RIGHT: begin
                w_src_c = 4'd14 - r_line;
                w_src_r = r_idx;
                w_dst_c = w_src_c + 4'd1;
                w_dst_r = r_idx;
                w_vert  = 1'b0;
            end
            c_DIR_LEFT: begin
                w_src_c = r_line + 4'd1;
                w_src_r = r_idx;
                w_dst_c = r_line;
                w_dst_r = r_idx;
                w_vert  = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_src_occ = r_work[w_src_r][w_src_c];
    assign w_dst_occ = r_work[w_dst_r][w_dst_c];

`ifdef SAND_DIAGONAL_EN
    logic        r_pref;
    logic [3:0]  w_lat;
    logic [3:0]  w_mn_r;
    logic [3:0]  w_mn_c;
    logic [3:0]  w_pl_r;
    logic [3:0]  w_pl_c;
    logic        w_mn_ok;
    logic        w_pl_ok;

    always_ff @(posedge clock) begin
        if (reset)
            r_pref <= 1'b0;
        else if ((r_state == c_COMMIT) && (r_dir != c_DIR_NONE))
            r_pref <= ~r_pref;
    end

    // Diagonal candidates sit in the destination line, one step either side laterally.
    always_comb begin
        w_lat   = w_vert ? w_src_c : w_src_r;
        w_mn_r  = w_vert ? w_dst_r : (w_dst_r - 4'd1);
        w_mn_c  = w_vert ? (w_dst_c - 4'd1) : w_dst_c;
        w_pl_r  = w_vert ? w_dst_r : (w_dst_r + 4'd1);
        w_pl_c  = w_vert ? (w_dst_c + 4'd1) : w_dst_c;
        w_mn_ok = (w_lat != 4'd0)  && !r_work[w_mn_r][w_mn_c];
        w_pl_ok = (w_lat != 4'd15) && !r_work[w_pl_r][w_pl_c];
        w_move  = 1'b0;
        w_mv_r  = w_dst_r;
        w_mv_c  = w_dst_c;
        if (w_src_occ) begin
            if (!w_dst_occ) begin
                w_move = 1'b1;
            end else if (!r_pref && w_mn_ok) begin
                w_move = 1'b1;  w_mv_r = w_mn_r;  w_mv_c = w_mn_c;
            end else if (w_pl_ok) begin
                w_move = 1'b1;  w_mv_r = w_pl_r;  w_mv_c = w_pl_c;
            end else if (r_pref && w_mn_ok) begin
                w_move = 1'b1;  w_mv_r = w_mn_r;  w_mv_c = w_mn_c;
            end
        end
    end
`else
    always_comb begin
        w_move = w_src_occ && !w_dst_occ;
        w_mv_r = w_dst_r;
        w_mv_c = w_dst_c;
    end
`endif

    // ------------------------------------------------------------------
    // Work grid, display buffer and pass bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_work      <= c_RESET_GRID;
            r_matrix    <= c_RESET_GRID;
            r_dir       <= c_DIR_NONE;
            r_line      <= 4'd0;
            r_idx       <= 4'd0;
            r_commit    <= 1'b0;
            r_pass_done <= 1'b0;
        end else begin
            r_commit    <= (r_state == c_COMMIT);
            r_pass_done <= r_commit;
            if (r_commit)
                r_matrix <= r_work;
            if (w_accept) begin
                r_dir  <= w_dir;
                r_line <= 4'd0;
                r_idx  <= 4'd0;
            end
            // A seed landing on the commit edge overrides the copied cell in both buffers.
            if (w_seed) begin
                r_work[bus.wr_row][bus.wr_col]   <= bus.wr_val;
                r_matrix[bus.wr_row][bus.wr_col] <= bus.wr_val;
            end
            if (r_state == c_SCAN) begin
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd15)
                    r_line <= r_line + 4'd1;
                if (w_move) begin
                    r_work[w_src_r][w_src_c] <= 1'b0;
                    r_work[w_mv_r][w_mv_c]   <= 1'b1;
                end
            end
        end
    end

    assign w_flat = r_matrix;

    always_comb begin
        w_grains = '0;
        for (int i = 0; i < 256; i++)
            w_grains = w_grains + {8'd0, w_flat[i]};
    end

    assign bus.matrix    = r_matrix;
    assign bus.grains    = w_grains;
    assign bus.busy      = w_busy;
    assign bus.pass_done = r_pass_done;

endmodule
`default_nettype wire

// File: tb/tb_sand_grid.sv
`default_nettype none
// ============================================================================
// Module : tb_sand_grid
// Brief  : Directed vector table plus hand sequences for sand_grid.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sand_grid;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sand_grid_if bus();

    sand_grid #(.THRESH(16'sd2000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [15:0][15:0] RESET_GRID = {{12{16'h0000}}, {4{16'hFFFF}}};

    typedef struct {
        logic signed [15:0] ax;
        logic signed [15:0] ay;
        int                 lat;
        int                 er;
        int                 ec;
    } vec_t;

    vec_t vecs [13];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.step = 1'b0;
        bus.wr_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cell(input int r, input int c, input logic v);
        bus.wr_en  = 1'b1;
        bus.wr_row = 4'(r);
        bus.wr_col = 4'(c);
        bus.wr_val = v;
        tick();
        bus.wr_en  = 1'b0;
    endtask

    task automatic clear_top();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++)
                write_cell(r, c, 1'b0);
    endtask

    // Pulses step, returns cycles from accepting edge to pass_done (-1 on timeout).
    task automatic do_step(input logic signed [15:0] ax, input logic signed [15:0] ay,
                           output int lat, output logic busy_seen);
        bus.accel_x = ax;
        bus.accel_y = ay;
        bus.step    = 1'b1;
        tick();
        bus.step    = 1'b0;
        bus.wr_en   = 1'b0;
        busy_seen   = bus.busy;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (bus.pass_done) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [15:0][15:0] rows_full(input int lo);
        logic [15:0][15:0] m;
        m = '0;
        for (int r = lo; r < lo + 4; r++) m[r] = 16'hFFFF;
        return m;
    endfunction

    initial begin
        int lat;
        logic b;
        int pd;
        logic [15:0][15:0] exp_m;

        vecs[0]  = '{16'sd0,     16'sd4000,  242, 8, 7};
        vecs[1]  = '{16'sd0,    -16'sd4000,  242, 6, 7};
        vecs[2]  = '{16'sd4000,  16'sd0,     242, 7, 8};
        vecs[3]  = '{-16'sd4000, 16'sd0,     242, 7, 6};
        vecs[4]  = '{16'sd1999, -16'sd1999,  2,   7, 7};
        vecs[5]  = '{16'sd2000,  16'sd0,     2,   7, 7};
        vecs[6]  = '{16'sd2001,  16'sd0,     242, 7, 8};
        vecs[7]  = '{16'sd3000, -16'sd3000,  242, 7, 8};
        vecs[8]  = '{-16'sd3000, 16'sd3000,  242, 7, 6};
        vecs[9]  = '{16'sd100,  -16'sd2500,  242, 6, 7};
        vecs[10] = '{16'sh8000,  16'sd32767, 242, 7, 6};
        vecs[11] = '{-16'sd2500, 16'sd2600,  242, 8, 7};
        vecs[12] = '{16'sd0,     16'sh8000,  242, 6, 7};

        bus.step = 1'b0; bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_val = 1'b0; bus.accel_x = '0; bus.accel_y = '0;
        do_reset();

        // Reset state
        check("reset_matrix", bus.matrix, RESET_GRID);
        check_i("reset_grains", int'(bus.grains), 64);
        check_i("reset_busy", int'(bus.busy), 0);
        check_i("reset_pass_done", int'(bus.pass_done), 0);

        // Seed writes in IDLE
        write_cell(5, 6, 1'b1);
        check_i("seed_bit", int'(bus.matrix[5][6]), 1);
        check_i("seed_grains_up", int'(bus.grains), 65);
        write_cell(5, 6, 1'b0);
        check_i("seed_grains_down", int'(bus.grains), 64);

        // Repeated DOWN passes settle the block on the floor
        for (int k = 1; k <= 13; k++) begin
            do_step(16'sd0, 16'sd4000, lat, b);
            if (k == 1) begin
                check_i("down_busy", int'(b), 1);
                check_i("down_latency", lat, 242);
            end
            check($sformatf("down_pass%0d", k), bus.matrix, rows_full(k > 12 ? 12 : k));
        end
        check_i("down_grains", int'(bus.grains), 64);
        tick();
        check_i("pass_done_width", int'(bus.pass_done), 0);

        // Write coincident with step is dropped
        bus.wr_en = 1'b1; bus.wr_row = 4'd0; bus.wr_col = 4'd0; bus.wr_val = 1'b1;
        do_step(16'sd0, 16'sd0, lat, b);
        check_i("step_vs_wr_lat", lat, 2);
        check("step_vs_wr_matrix", bus.matrix, rows_full(12));

        // Step while busy ignored, write while busy dropped
        do_reset();
        bus.accel_x = 16'sd0; bus.accel_y = 16'sd4000; bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        pd = 0;
        for (int i = 1; i < 600; i++) begin
            if (i == 50) begin
                bus.wr_en = 1'b1; bus.wr_row = 4'd10; bus.wr_col = 4'd3; bus.wr_val = 1'b1;
            end
            if (i == 100) begin
                check_i("busy_at_second_step", int'(bus.busy), 1);
                bus.step = 1'b1;
            end
            tick();
            bus.wr_en = 1'b0;
            bus.step  = 1'b0;
            if (bus.pass_done) pd++;
        end
        check_i("busy_step_pulses", pd, 1);
        check("busy_step_matrix", bus.matrix, rows_full(1));

        // Reset mid-pass aborts
        do_reset();
        bus.accel_x = 16'sd0; bus.accel_y = 16'sd4000; bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        for (int i = 0; i < 119; i++) tick();
        reset = 1'b1;
        tick();
        check_i("abort_busy", int'(bus.busy), 0);
        check("abort_matrix", bus.matrix, RESET_GRID);
        check_i("abort_pass_done", int'(bus.pass_done), 0);
        reset = 1'b0;
        pd = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.pass_done) pd++;
        end
        check_i("abort_no_pulse", pd, 0);

        // Stacked pair on the floor
        do_reset();
        clear_top();
        write_cell(15, 5, 1'b1);
        write_cell(14, 5, 1'b1);
        do_step(16'sd0, 16'sd4000, lat, b);
        exp_m = '0;
        exp_m[15][5] = 1'b1;
`ifdef SAND_DIAGONAL_EN
        exp_m[15][4] = 1'b1;
`else
        exp_m[14][5] = 1'b1;
`endif
        check("stack_matrix", bus.matrix, exp_m);
        check_i("stack_grains", int'(bus.grains), 2);

        // Direction decode table: one grain at (7,7)
        for (int i = 0; i < 13; i++) begin
            do_reset();
            clear_top();
            write_cell(7, 7, 1'b1);
            do_step(vecs[i].ax, vecs[i].ay, lat, b);
            exp_m = '0;
            exp_m[vecs[i].er][vecs[i].ec] = 1'b1;
            check_i($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_matrix", i), bus.matrix, exp_m);
            check_i($sformatf("vec%0d_grains", i), int'(bus.grains), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
